dcache: RTL

Direct-mapped, write-back, write-allocate data cache between the single-cycle CPU and the word-organised data memory. It is the responder on the CPU's READ/WRITE/BUSYWAIT byte interface and the initiator on the memory's 32-bit block interface. The CPU stalls on BUSYWAIT. Hits complete with no stall. Misses run a write-back/fetch sequence.

---
 rtl/dcache_if.sv | 31 +++
 rtl/dcache.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dcache_if.sv
// dcache_if: bundles the CPU-side byte interface and the memory-side block
// interface of the data cache.
//   CPU side   : READ, WRITE, ADDRESS[7:0], WRITEDATA[7:0] -> READDATA[7:0], BUSYWAIT
//   Memory side: mem_read, mem_write, mem_address[5:0], mem_writedata[31:0]
//                <- mem_readdata[31:0], mem_busywait
// Modport slave is the cache's view; modport master is the environment's view
// (CPU plus data memory).
interface dcache_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
    output READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
    input  READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
// 8 lines x 4 bytes; byte address = {tag[7:5], index[4:2], offset[1:0]}.
// Ports:
//   CLK    - system clock
//   RESET  - synchronous, active-high reset (clears valid/dirty, FSM to IDLE)
//   bus    - dcache_if.slave: CPU READ/WRITE/ADDRESS/WRITEDATA in,
//            READDATA/BUSYWAIT out; memory block request out
//            (mem_read/mem_write/mem_address/mem_writedata), mem_readdata and
//            mem_busywait in.
// Hits complete in the same cycle; misses run WRITE_BACK (if dirty), FETCH,
// ALLOCATE, then the access re-hits in IDLE.
module dcache (
  input  logic     CLK,
  input  logic     RESET,
  dcache_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FETCH,
    ALLOCATE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [2:0]  tag_q  [8];
  logic [2:0]  tag_d  [8];
  logic [31:0] data_q [8];
  logic [31:0] data_d [8];
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic [2:0]  idx;
  logic [2:0]  tag_in;
  logic [4:0]  bit_off;
  logic        hit;

  assign idx     = bus.ADDRESS[4:2];
  assign tag_in  = bus.ADDRESS[7:5];
  assign bit_off = {bus.ADDRESS[1:0], 3'b000};
  assign hit     = valid_q[idx] && (tag_q[idx] == tag_in);

  // CPU-facing outputs are combinational so hits need no stall.
  assign bus.READDATA = hit ? data_q[idx][bit_off +: 8] : '0;
  assign bus.BUSYWAIT = (bus.READ || bus.WRITE) && !((state_q == IDLE) && hit);

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

  always_comb begin
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    case (state_q)
      WRITE_BACK: begin
        bus.mem_address   = {tag_q[idx], idx};
        bus.mem_writedata = data_q[idx];
      end
      FETCH: begin
        bus.mem_address = bus.ADDRESS[7:2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // WRITE wins if READ is also asserted; a read hit changes nothing.
        if (bus.WRITE && hit) begin
          data_d[idx][bit_off +: 8] = bus.WRITEDATA;
          dirty_d[idx]              = 1'b1;
        end else if ((bus.READ || bus.WRITE) && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : FETCH;
        end
      end
      WRITE_BACK: begin
        if (!bus.mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        if (!bus.mem_busywait) begin
          data_d[idx]  = bus.mem_readdata;
          tag_d[idx]   = tag_in;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = ALLOCATE;
        end
      end
      ALLOCATE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Memory strobes are decoded from the next state so they are registered
    // and line up exactly with the WRITE_BACK / FETCH states.
    mem_read_d  = (state_d == FETCH);
    mem_write_d = (state_d == WRITE_BACK);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

endmodule
